// File: rtl/cmul_share_ctrl.sv
// Round-robin, frame-locked arbiter that shares the twiddle multiplier between two butterfly stages.
// A result returns MUL_LATENCY edges after its beat is accepted; requesters stall only while arbitration holds them off, and results are never held back.
module cmul_share_ctrl #(
    parameter int DATA_WIDTH  = 21,
    parameter int TWID_WIDTH  = 16,
    parameter int MUL_LATENCY = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                s0_valid,
    output logic                                s0_ready,
    input  logic                                s0_last,
    input  logic [DATA_WIDTH-1:0]               s0_a_r,
    input  logic [DATA_WIDTH-1:0]               s0_a_i,
    input  logic [TWID_WIDTH-1:0]               s0_b_r,
    input  logic [TWID_WIDTH-1:0]               s0_b_i,
    input  logic                                s1_valid,
    output logic                                s1_ready,
    input  logic                                s1_last,
    input  logic [DATA_WIDTH-1:0]               s1_a_r,
    input  logic [DATA_WIDTH-1:0]               s1_a_i,
    input  logic [TWID_WIDTH-1:0]               s1_b_r,
    input  logic [TWID_WIDTH-1:0]               s1_b_i,
    output logic [DATA_WIDTH-1:0]               m_a_r,
    output logic [DATA_WIDTH-1:0]               m_a_i,
    output logic [TWID_WIDTH-1:0]               m_b_r,
    output logic [TWID_WIDTH-1:0]               m_b_i,
    input  logic [DATA_WIDTH+TWID_WIDTH:0]      m_c_r,
    input  logic [DATA_WIDTH+TWID_WIDTH:0]      m_c_i,
    output logic [1:0]                          res_valid,
    output logic [DATA_WIDTH+TWID_WIDTH:0]      res_c_r,
    output logic [DATA_WIDTH+TWID_WIDTH:0]      res_c_i,
    output logic                                busy
);

    localparam int NTAG = MUL_LATENCY + 1;

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    typedef struct packed {
        logic vld;
        logic id;
    } tag_t;

    state_t                  state;
    logic                    rr_ptr;
    tag_t [NTAG-1:0]         tag_q;
    logic [TWID_WIDTH-1:0]   b_stg_r;
    logic [TWID_WIDTH-1:0]   b_stg_i;

    logic                    acc0;
    logic                    acc1;
    logic                    accept;
    logic                    sel_last;
    logic [DATA_WIDTH-1:0]   sel_a_r;
    logic [DATA_WIDTH-1:0]   sel_a_i;
    logic [TWID_WIDTH-1:0]   sel_b_r;
    logic [TWID_WIDTH-1:0]   sel_b_i;
    tag_t                    new_tag;
    tag_t                    out_tag;
    logic                    any_tag;

    // Ready depends only on state, rr_ptr and valid, never on the beat payload.
    always_comb begin
        s0_ready = 1'b0;
        s1_ready = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (s0_valid && s1_valid) begin
                        s0_ready = ~rr_ptr;
                        s1_ready = rr_ptr;
                    end else begin
                        s0_ready = s0_valid;
                        s1_ready = s1_valid;
                    end
                end
                LOCK0:   s0_ready = 1'b1;
                LOCK1:   s1_ready = 1'b1;
                default: begin
                    s0_ready = 1'b0;
                    s1_ready = 1'b0;
                end
            endcase
        end
    end

    assign acc0   = s0_valid & s0_ready;
    assign acc1   = s1_valid & s1_ready;
    assign accept = acc0 | acc1;

    always_comb begin
        if (acc1) begin
            sel_last = s1_last;
            sel_a_r  = s1_a_r;
            sel_a_i  = s1_a_i;
            sel_b_r  = s1_b_r;
            sel_b_i  = s1_b_i;
        end else begin
            sel_last = s0_last;
            sel_a_r  = s0_a_r;
            sel_a_i  = s0_a_i;
            sel_b_r  = s0_b_r;
            sel_b_i  = s0_b_i;
        end
    end

    assign new_tag.vld = accept;
    assign new_tag.id  = acc1;

    // Twiddle goes through a staging register so it reaches the multiplier one edge after its data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rr_ptr  <= 1'b0;
            m_a_r   <= '0;
            m_a_i   <= '0;
            m_b_r   <= '0;
            m_b_i   <= '0;
            b_stg_r <= '0;
            b_stg_i <= '0;
            tag_q   <= '0;
        end else begin
            m_b_r <= b_stg_r;
            m_b_i <= b_stg_i;
            tag_q <= {tag_q[NTAG-2:0], new_tag};
            if (accept) begin
                m_a_r   <= sel_a_r;
                m_a_i   <= sel_a_i;
                b_stg_r <= sel_b_r;
                b_stg_i <= sel_b_i;
                if (sel_last) begin
                    state  <= IDLE;
                    rr_ptr <= ~acc1;
                end else begin
                    state <= acc1 ? LOCK1 : LOCK0;
                end
            end else begin
                m_a_r   <= '0;
                m_a_i   <= '0;
                b_stg_r <= '0;
                b_stg_i <= '0;
            end
        end
    end

    always_comb begin
        any_tag = 1'b0;
        for (int i = 0; i < NTAG; i++) begin
            any_tag = any_tag | tag_q[i].vld;
        end
    end

    assign out_tag   = tag_q[NTAG-1];
    assign res_valid = out_tag.vld ? (out_tag.id ? 2'b10 : 2'b01) : 2'b00;
    assign res_c_r   = m_c_r;
    assign res_c_i   = m_c_i;
    assign busy      = (state != IDLE) | any_tag;

endmodule

// File: doc/cmul_share_ctrl.md
# cmul_share_ctrl

Two-requester arbiter and sequencer for the single shared complex twiddle multiplier in the FFT datapath. It accepts (data, twiddle) beats from two butterfly stages over valid/ready. It grants the multiplier per frame in round-robin order and drives the multiplier inputs with the one-cycle data-to-twiddle skew that the multiplier requires. A tag pipeline matched to the multiplier latency steers each product back to its requester.

## Interface
Parameters:
- DATA_WIDTH, 21, width of signed data components
- TWID_WIDTH, 16, width of signed twiddle components
- MUL_LATENCY, 4, clock edges from an m_a_* register update to the matching m_c_* update; fixed by the multiplier

Ports (clock and reset first):
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous active-high reset
- s0_valid / s1_valid  input  1  requester beat valid
- s0_ready / s1_ready  output  1  requester beat accepted this cycle when valid&ready
- s0_last / s1_last  input  1  final beat of requester frame
- s0_a_r, s0_a_i, s1_a_r, s1_a_i  input  DATA_WIDTH  data operand
- s0_b_r, s0_b_i, s1_b_r, s1_b_i  input  TWID_WIDTH  twiddle operand
- m_a_r, m_a_i  output  DATA_WIDTH  to multiplier data inputs, registered
- m_b_r, m_b_i  output  TWID_WIDTH  to multiplier twiddle inputs, registered
- m_c_r, m_c_i  input  DATA_WIDTH+TWID_WIDTH+1  multiplier product
- res_valid  output  2  one-hot; bit k means the product belongs to requester k
- res_c_r, res_c_i  output  DATA_WIDTH+TWID_WIDTH+1  product, combinational pass-through of m_c_*
- busy  output  1  frame locked or any product in flight

## Operation
- FSM states: IDLE, LOCK0, LOCK1.
- IDLE behaviour:
  - If exactly one sK_valid is high, that requester's sK_ready is high.
  - If both are high, the requester selected by rr_ptr gets ready; the other gets 0.
  - If neither is high, both readies are 0.
  - An accepted beat with last=0 moves the FSM to LOCKk. An accepted beat with last=1 stays in IDLE.
- LOCKk behaviour: sk_ready = 1 and the other ready = 0. An accepted beat with last=1 returns the FSM to IDLE.
- rr_ptr: resets to 0. It is set to the other port whenever a beat with last=1 from port k is accepted, including single-beat frames in IDLE.
- Throughput: one beat per cycle. There is no backpressure on results; requesters must always sink res_valid.
- Accepted beat at edge N:
  - m_a_* takes sK_a_* at edge N.
  - m_b_* takes sK_b_* at edge N+1, from an internal staging register.
- Non-beat cycles: the m_a_* register loads 0. The m_b_* register loads its staging value, which is 0 if no beat was accepted in the previous cycle.
- Tag pipeline: MUL_LATENCY+1 stages of {valid, id}.
  - Stage 0 loads {accept, granted id} every edge.
  - The last stage drives res_valid = valid ? onehot(id) : 2'b00.
- busy = (state != IDLE) OR any tag stage valid.
- No arithmetic is performed here. Widths pass through unchanged. Sign interpretation belongs to the multiplier.

## Timing
- Reset values, visible the cycle after the rst edge:
  - state = IDLE, rr_ptr = 0.
  - m_a_*, m_b_*, and the staging register = 0.
  - All tag stages invalid, res_valid = 2'b00, busy = 0.
- sK_ready is 0 while rst is high.
- Ready is combinational from state, rr_ptr and sK_valid. sK_valid must not depend on sK_ready.
- Latency: beat accepted at edge N produces res_valid[k] and its product in the cycle after edge N+MUL_LATENCY (N+4 by default).
- Reset mid-operation:
  - In-flight tags are discarded; their products are never flagged.
  - Any lock is dropped. The next frame is arbitrated fresh with rr_ptr = 0.
- Simultaneous events are legal and independent:
  - a new request while a product is in flight;
  - last accepted while the other port is requesting, so that port is granted in the next cycle;
  - a result arriving on the same cycle a beat is accepted.
- Back-to-back frames: after last from port 0, if both ports are valid, port 1 is granted on the very next cycle with no bubble.

## Test plan
- Reset, then s0 single beat:
  - Stimulus: s0 beat a=(100,-50), b=(16384,0), last=1 at edge 0.
  - Expect m_a=(100,-50) after edge 0 and m_b=(16384,0) after edge 1.
  - Expect res_valid=2'b01 only in the cycle after edge 4, carrying the model product.
- Contention:
  - Stimulus: both ports valid from reset, each sending 3-beat frames.
  - Expect s0 to win (rr_ptr=0) and hold 3 consecutive grants, with s1_ready=0 throughout.
  - Then s1 gets 3 grants with no bubble.
  - Expect the res_valid sequence 01,01,01,10,10,10, offset by 4 cycles.
- Lock hold with gaps:
  - Stimulus: s0 drops valid mid-frame while s1 is valid.
  - Expect s1_ready to stay 0 until s0 completes with last.
- Streaming:
  - Stimulus: 64 back-to-back single-beat alternating frames with random operands.
  - Expect every product matched by a scoreboard, no drops, and strict alternation.
- Reset mid-flight:
  - Stimulus: assert rst 2 cycles after accepting 2 beats.
  - Expect no res_valid pulse afterwards, and busy=0 and all m_* = 0 the cycle after reset.
- Idle skew check:
  - Stimulus: a single beat followed by an idle cycle.
  - Expect m_a=0 in the idle cycle while m_b still holds that beat's twiddle, then m_b=0.
